// File: rtl/load_memory_decoder.sv
// Load path between execute/LSU control and the data-memory port: issues a word-aligned
// read, then extracts and zero/sign-extends a byte, halfword or word from the returned word.
module load_memory_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_type_,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            misaligned_exception
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] LOAD_B = 2'd0;
  localparam logic [1:0] LOAD_H = 2'd1;
  localparam logic [1:0] LOAD_W = 2'd2;

  state_t            state_r;
  logic [1:0]        type_r;
  logic              unsigned_r;
  logic [XLEN-1:0]   addr_r;

  // Reserved type 3 is reported as misaligned so it never reaches memory.
  function automatic logic is_misaligned(input logic [1:0] ty, input logic [1:0] off);
    logic m;
    case (ty)
      LOAD_B:  m = 1'b0;
      LOAD_H:  m = (off == 2'd3);
      LOAD_W:  m = (off != 2'd0);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] decode_load(input logic [1:0] ty, input logic uns,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] r;
    shifted = rdata >> {off, 3'b000};
    case (ty)
      LOAD_B: begin
        if (uns) r = {{(XLEN-8){1'b0}}, shifted[7:0]};
        else     r = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      LOAD_H: begin
        if (uns) r = {{(XLEN-16){1'b0}}, shifted[15:0]};
        else     r = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      LOAD_W:  r = rdata;
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // The memory address is a direct function of the latched request, so it stays stable in REQ.
  assign mem_addr = {addr_r[XLEN-1:2], 2'b00};

  // Request/response FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r              <= IDLE;
      type_r               <= 2'd0;
      unsigned_r           <= 1'b0;
      addr_r               <= {XLEN{1'b0}};
      req_ready            <= 1'b1;
      mem_valid            <= 1'b0;
      resp_valid           <= 1'b0;
      resp_data            <= {XLEN{1'b0}};
      misaligned_exception <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            type_r     <= req_type_;
            unsigned_r <= req_unsigned;
            addr_r     <= req_addr;
            req_ready  <= 1'b0;
            if (is_misaligned(req_type_, req_addr[1:0])) begin
              state_r              <= RESP;
              resp_valid           <= 1'b1;
              resp_data            <= {XLEN{1'b0}};
              misaligned_exception <= 1'b1;
            end else begin
              state_r   <= REQ;
              mem_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            resp_data            <= decode_load(type_r, unsigned_r, addr_r[1:0], mem_rdata);
            misaligned_exception <= 1'b0;
            resp_valid           <= 1'b1;
            state_r              <= RESP;
          end
        end
        RESP: begin
          // req_ready returns only after the handshake edge, never within it.
          if (resp_ready) begin
            resp_valid           <= 1'b0;
            misaligned_exception <= 1'b0;
            req_ready            <= 1'b1;
            state_r              <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          mem_valid  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_memory_decoder.sv
// Scoreboard bench for load_memory_decoder: expected results are queued when a load is
// issued and popped at the response handshake.
module tb_load_memory_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type_;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        misaligned_exception;

  int checks = 0;
  int errors = 0;
  int mem_hs = 0;
  int resp_hs = 0;
  logic [32:0] sb_q[$];

  load_memory_decoder #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type_(req_type_),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .misaligned_exception(misaligned_exception)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_valid && mem_ready) mem_hs <= mem_hs + 1;
    if (resp_valid && resp_ready) resp_hs <= resp_hs + 1;
  end

  // Reference result {exception, data} for one load.
  function automatic logic [32:0] ref_load(input logic [1:0] t, input logic u,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    off = a[1:0];
    if (t == 2'd3 || (t == 2'd1 && off == 2'd3) || (t == 2'd2 && off != 2'd0))
      return {1'b1, 32'h0};
    b = rd[8*off +: 8];
    if (t == 2'd0) return {1'b0, (u ? 24'h0 : {24{b[7]}}), b};
    if (t == 2'd1) begin
      h = rd[8*off +: 16];
      return {1'b0, (u ? 16'h0 : {16{h[15]}}), h};
    end
    return {1'b0, rd};
  endfunction

  // Issue one load at a negedge in IDLE and walk it through to the response handshake.
  task automatic do_load(input logic [1:0] t, input logic u, input logic [31:0] a,
                         input logic [31:0] rd, input int mrdy_dly, input int rv_dly,
                         input int rrdy_dly, input logic [32:0] exp);
    logic [32:0] got;
    logic [31:0] held;
    int hs0;
    int rhs0;
    hs0  = mem_hs;
    rhs0 = resp_hs;
    sb_q.push_back(exp);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle got %b exp 1", req_ready); end
    req_valid = 1'b1; req_type_ = t; req_unsigned = u; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_type_ = 2'($urandom);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_busy got %b exp 0", req_ready); end
    if (exp[32]) begin
      checks++;
      if (mem_valid !== 1'b0 || resp_valid !== 1'b1) begin
        errors++; $display("FAIL misaligned_timing mem_valid %b resp_valid %b exp 0 1", mem_valid, resp_valid);
      end
    end else begin
      for (int i = 0; i <= mrdy_dly; i++) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== {a[31:2], 2'b00}) begin
          errors++; $display("FAIL mem_req mem_valid %b addr %h exp 1 %h", mem_valid, mem_addr, {a[31:2], 2'b00});
        end
        mem_ready  = (i == mrdy_dly);
        mem_rvalid = (i < mrdy_dly);
        mem_rdata  = $urandom;
        @(negedge clk);
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      checks++;
      if (mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL wait_state mem_valid %b resp_valid %b exp 0 0", mem_valid, resp_valid);
      end
      for (int i = 0; i < rv_dly; i++) begin
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL wait_hold resp_valid %b exp 0", resp_valid); end
      end
      resp_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    checks++;
    if (mem_hs != hs0 + (exp[32] ? 0 : 1)) begin
      errors++; $display("FAIL mem_handshakes got %0d exp %0d", mem_hs - hs0, exp[32] ? 0 : 1);
    end
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_valid got %b exp 1", resp_valid); end
    held = resp_data;
    for (int i = 0; i < rrdy_dly; i++) begin
      resp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0 || mem_valid !== 1'b0) begin
        errors++; $display("FAIL resp_hold valid %b data %h req_ready %b mem_valid %b exp 1 %h 0 0",
                           resp_valid, resp_data, req_ready, mem_valid, held);
      end
    end
    resp_ready = 1'b1;
    got = sb_q.pop_front();
    checks++;
    if ({misaligned_exception, resp_data} !== got) begin
      errors++; $display("FAIL resp_result got exc %b data %h exp exc %b data %h",
                         misaligned_exception, resp_data, got[32], got[31:0]);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_hs != rhs0 + 1) begin
      errors++; $display("FAIL resp_done valid %b req_ready %b responses %0d exp 0 1 1",
                         resp_valid, req_ready, resp_hs - rhs0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_type_ = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0 ||
        misaligned_exception !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_values req_ready %b mem_valid %b resp_valid %b data %h exc %b addr %h",
                         req_ready, mem_valid, resp_valid, resp_data, misaligned_exception, mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_extend();
    do_load(2'd0, 1'b0, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 0, {1'b0, 32'hFFFF_FF80});
    do_load(2'd1, 1'b1, 32'h0000_2001, 32'h12AB_CD34, 0, 0, 0, {1'b0, 32'h0000_ABCD});
    do_load(2'd1, 1'b0, 32'h0000_2001, 32'h12AB_CD34, 0, 0, 0, {1'b0, 32'hFFFF_ABCD});
    do_load(2'd2, 1'b0, 32'h0000_2004, 32'h8765_4321, 0, 0, 0, {1'b0, 32'h8765_4321});
  endtask

  task automatic test_misaligned();
    do_load(2'd2, 1'b0, 32'h0000_3002, 32'hFFFF_FFFF, 0, 0, 0, {1'b1, 32'h0});
    do_load(2'd1, 1'b1, 32'h0000_3003, 32'hFFFF_FFFF, 0, 0, 1, {1'b1, 32'h0});
    do_load(2'd3, 1'b0, 32'h0000_3000, 32'hFFFF_FFFF, 0, 0, 0, {1'b1, 32'h0});
  endtask

  task automatic test_backpressure();
    do_load(2'd2, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 4, 1, 3, {1'b0, 32'hCAFE_F00D});
  endtask

  task automatic test_reset_mid_wait();
    int rhs0;
    rhs0 = resp_hs;
    req_valid = 1'b1; req_type_ = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0000_6000;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0 ||
        misaligned_exception !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL async_reset req_ready %b mem_valid %b resp_valid %b data %h exc %b addr %h",
                         req_ready, mem_valid, resp_valid, resp_data, misaligned_exception, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; resp_ready = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
        errors++; $display("FAIL stray_rvalid resp_valid %b req_ready %b mem_valid %b exp 0 1 0",
                           resp_valid, req_ready, mem_valid);
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checks++;
    if (resp_hs != rhs0) begin errors++; $display("FAIL reset_resp_count got %0d exp 0", resp_hs - rhs0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int hs0;
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    hs0 = mem_hs;
    for (int off = 0; off < 4; off++)
      do_load(2'd0, 1'b1, 32'h0000_7000 + 32'(off), 32'hDDCC_BBAA, 0, 0, 0, {1'b0, 24'h0, bytes[off]});
    checks++;
    if (mem_hs != hs0 + 4) begin errors++; $display("FAIL b2b_mem_handshakes got %0d exp 4", mem_hs - hs0); end
  endtask

  task automatic test_random();
    logic [1:0]  t;
    logic        u;
    logic [31:0] a;
    logic [31:0] rd;
    for (int n = 0; n < 12; n++) begin
      t = 2'($urandom_range(0, 3)); u = 1'($urandom); a = $urandom; rd = $urandom;
      do_load(t, u, a, rd, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              ref_load(t, u, a, rd));
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_misaligned();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_memory_decoder.md
Name: load_memory_decoder

Overview:
- Load-side counterpart of the store path: accepts a load request from the execute stage and issues a word-aligned read to the data-memory port.
- Extracts the addressed byte, halfword or word from the returned word, zero- or sign-extends it, and returns it on a response handshake.
- Detects misaligned loads and reports them without touching memory.
- Sits between the execute/LSU control and the data-memory interface.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  load request valid.
- req_ready  output  1  block can accept a request (IDLE only).
- req_type_  input  2  0=LOAD_B, 1=LOAD_H, 2=LOAD_W, 3=reserved.
- req_unsigned  input  1  1=zero-extend, 0=sign-extend; ignored for LOAD_W.
- req_addr  input  32  byte address of the load.
- mem_valid  output  1  memory read request valid.
- mem_ready  input  1  memory accepts the request.
- mem_addr  output  32  {addr[31:2],2'b00}.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read data word.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  extended load result.
- misaligned_exception  output  1  qualifies resp_valid; 1 = load was misaligned.

Behaviour:
- States: IDLE, REQ, WAIT, RESP, encoded in a registered FSM.
- Reset: asynchronous to IDLE, with all outputs 0 except req_ready=1. Latched request fields are cleared to 0.
- IDLE:
  - req_ready=1.
  - On req_valid at the clock edge, latch type, unsigned flag and addr; offset = addr[1:0].
  - If the request is misaligned, go to RESP with misaligned_exception=1 and resp_data=0, and issue no memory request.
  - Otherwise go to REQ.
- Misaligned cases:
  - LOAD_H with offset 3.
  - LOAD_W with offset != 0.
  - Reserved type 3, at any offset.
- REQ:
  - mem_valid=1; mem_addr is held stable until mem_ready.
  - On mem_valid & mem_ready, go to WAIT.
  - mem_rvalid is ignored in REQ; memory never returns data in the handshake cycle.
- WAIT:
  - On mem_rvalid, register the decoded result into resp_data, set misaligned_exception=0, and go to RESP.
  - Waits indefinitely otherwise; there is no timeout.
- RESP:
  - resp_valid=1; resp_data and misaligned_exception are held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE.
  - No new request is accepted in the handshake cycle; req_ready rises the cycle after.
- Decode (off = latched offset):
  - LOAD_B: byte = rdata[8*off+7:8*off]; result = unsigned ? {24'b0,byte} : {{24{byte[7]}},byte}.
  - LOAD_H: half = rdata[8*off+15:8*off] for off 0..2; extended the same way to 32 bits.
  - LOAD_W: result = rdata.
- Latency:
  - Aligned load, accept at edge T: mem_valid during T+1.
  - Zero-wait memory (mem_ready at T+1, rvalid at T+2): resp_valid at T+3.
  - Misaligned load: resp_valid at T+1.
- Ordering: one outstanding load at a time; mem_valid is never asserted outside REQ.
- Stray data: mem_rvalid in IDLE, REQ or RESP is ignored, including data for a request aborted by reset.
- Reset mid-operation: the FSM returns to IDLE immediately and any pending response is discarded. The memory side must tolerate the abandoned request.
- resp_ready held high in IDLE/REQ/WAIT has no effect.

Test Plan:
- LOAD_B signed, addr 0x1003, rdata 0x80FF7F01 → mem_addr 0x1000, resp_data 0xFFFFFF80, misaligned_exception 0, resp_valid 3 cycles after accept with zero-wait memory.
- LOAD_H unsigned, addr 0x2001, rdata 0x12ABCD34 → resp_data 0x0000ABCD. The same request signed → 0xFFFFABCD.
- LOAD_W addr 0x3002 → no mem_valid ever, resp_valid the next cycle, misaligned_exception 1, resp_data 0. LOAD_H offset 3 and type 3 give the same result.
- Backpressure: mem_ready low for 4 cycles then high, rvalid 2 cycles later, resp_ready low for 3 cycles → mem_addr stable throughout, resp_data stable while resp_valid, exactly one response. req_ready is 0 until the cycle after the response handshake.
- Reset asserted asynchronously in WAIT, then mem_rvalid arrives after reset release → outputs go to reset values immediately, the stray rvalid is ignored, and no resp_valid is produced.
- Back-to-back: LOAD_B unsigned at offsets 0..3 of rdata 0xDDCCBBAA → results 0xAA, 0xBB, 0xCC, 0xDD in order, with one mem_valid handshake each.
